// File: rtl/tlp_tx_drain.sv
// Packet-mode drain from an FWFT TLP FIFO onto the 64-bit PCIe TX AXI-Stream port.
// Optional feature macro: TX_DISCONTINUE_EN (mark MAX_BEATS-truncated TLPs with tuser[3]).
module tlp_tx_drain #(
  parameter int CNT_W     = 8,
  parameter int MAX_BEATS = 40
) (
  input  logic             pcie_clk,
  input  logic             pcie_rst_n,
  input  logic             pkt_req,
  output logic             rd_en,
  input  logic             dout_tlast,
  input  logic [7:0]       dout_tkeep,
  input  logic [63:0]      dout_tdata,
  input  logic             empty,
  output logic             s_axis_tx_tvalid,
  input  logic             s_axis_tx_tready,
  output logic             s_axis_tx_tlast,
  output logic [7:0]       s_axis_tx_tkeep,
  output logic [63:0]      s_axis_tx_tdata,
  output logic [3:0]       s_axis_tx_tuser,
  output logic [CNT_W-1:0] pkt_pending,
  output logic             err_ovf,
  output logic             err_udr,
  output logic             err_long
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0] MAX_B = BEAT_W'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic              advance;
  logic              load;
  logic              force_last;
  logic              first_pop;
  logic              ovf_set;
  logic              udr_set;
  logic              long_set;
  logic [3:0]        tuser_val;

  // The output slot can take a new beat when it is empty or being accepted.
  assign advance = !s_axis_tx_tvalid || s_axis_tx_tready;

`ifdef TX_DISCONTINUE_EN
  assign tuser_val = force_last ? 4'h8 : 4'h0;
`else
  assign tuser_val = 4'h0;
`endif

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    rd_en      = 1'b0;
    load       = 1'b0;
    force_last = 1'b0;
    first_pop  = 1'b0;
    udr_set    = 1'b0;
    long_set   = 1'b0;
    case (state)
      IDLE: begin
        if ((cnt != '0) && !empty && advance) begin
          rd_en     = 1'b1;
          load      = 1'b1;
          first_pop = 1'b1;
          if (dout_tlast) begin
            beat_nxt = '0;
          end else begin
            beat_nxt  = BEAT_W'(1);
            state_nxt = SEND;
          end
        end
      end
      SEND: begin
        if (empty) begin
          udr_set = 1'b1;
        end else if (advance) begin
          rd_en = 1'b1;
          load  = 1'b1;
          if (dout_tlast) begin
            beat_nxt  = '0;
            state_nxt = IDLE;
          end else if ((beat + BEAT_W'(1)) == MAX_B) begin
            // Runaway packet: terminate it on the wire, discard the rest.
            force_last = 1'b1;
            long_set   = 1'b1;
            beat_nxt   = '0;
            state_nxt  = FLUSH;
          end else begin
            beat_nxt = beat + BEAT_W'(1);
          end
        end
      end
      FLUSH: begin
        if (!empty) begin
          rd_en = 1'b1;
          if (dout_tlast) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    ovf_set = 1'b0;
    case ({pkt_req, first_pop})
      2'b10: begin
        if (&cnt) ovf_set = 1'b1;
        else      cnt_nxt = cnt + CNT_W'(1);
      end
      2'b01:   cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      cnt      <= '0;
      err_ovf  <= 1'b0;
      err_udr  <= 1'b0;
      err_long <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      cnt      <= cnt_nxt;
      err_ovf  <= err_ovf | ovf_set;
      err_udr  <= err_udr | udr_set;
      err_long <= err_long | long_set;
    end
  end

  // Single output register stage toward the PCIe core.
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      s_axis_tx_tvalid <= 1'b0;
      s_axis_tx_tlast  <= 1'b0;
      s_axis_tx_tkeep  <= '0;
      s_axis_tx_tdata  <= '0;
      s_axis_tx_tuser  <= '0;
    end else if (load) begin
      s_axis_tx_tvalid <= 1'b1;
      s_axis_tx_tlast  <= dout_tlast | force_last;
      s_axis_tx_tkeep  <= dout_tkeep;
      s_axis_tx_tdata  <= dout_tdata;
      s_axis_tx_tuser  <= tuser_val;
    end else if (advance) begin
      s_axis_tx_tvalid <= 1'b0;
    end
  end

  assign pkt_pending = cnt;

endmodule

// File: doc/tlp_tx_drain.md
Name: tlp_tx_drain

Overview:
- Packet-mode drain stage that sits directly downstream of the Ethernet decapsulator's TLP FIFO (PCIE_FIFO64_TX entries, FWFT, dual-clock).
- Counts committed packets and starts reading only when at least one complete TLP is in the FIFO.
- Drives the 64-bit PCIe core TX AXI-Stream interface with full-throughput backpressure handling.
- Guards against runaway packets and counter overflow/underrun.

Parameters:
CNT_W, 8, width of committed-packet counter
MAX_BEATS, 40, maximum beats per TLP before forced termination (4 DW hdr + 256 B payload = 34 beats, plus margin)

Ports:
pcie_clk  in  1  PCIe user clock; all logic on rising edge
pcie_rst_n  in  1  asynchronous, active-low reset
pkt_req  in  1  one-cycle pulse: one complete packet (ending in tlast) written to FIFO; already synchronised into pcie_clk
rd_en  out  1  FIFO pop (FWFT; dout valid while !empty)
dout_tlast  in  1  FIFO head tlast
dout_tkeep  in  8  FIFO head tkeep
dout_tdata  in  64  FIFO head tdata
empty  in  1  FIFO empty
s_axis_tx_tvalid  out  1  TX beat valid
s_axis_tx_tready  in  1  PCIe core ready
s_axis_tx_tlast  out  1  last beat of TLP
s_axis_tx_tkeep  out  8  byte enables
s_axis_tx_tdata  out  64  TLP data
s_axis_tx_tuser  out  4  TX sideband; bit3 = src_dsc
pkt_pending  out  CNT_W  current committed-packet count
err_ovf  out  1  sticky: pkt_req at counter max
err_udr  out  1  sticky: FIFO empty mid-packet
err_long  out  1  sticky: MAX_BEATS reached without tlast

Behaviour:
- Reset (async assert, sync deassert assumed at integration):
  - All outputs 0; counter 0; beat count 0; state IDLE; output register empty.
- Counter:
  - +1 on pkt_req; -1 on popping the first beat of a packet (state IDLE→SEND).
  - Simultaneous +1/-1: unchanged.
  - pkt_req at all-ones: hold at max, set err_ovf.
  - Decrement occurs only when count > 0, so the counter never goes negative.
- Output register:
  - One stage holding tvalid/tlast/tkeep/tdata/tuser. "Advance" = !s_axis_tx_tvalid || s_axis_tx_tready.
  - rd_en = advance && !empty && state permits a pop; rd_en is combinational on tready.
  - Load on rd_en; clear tvalid on advance without rd_en.
  - Outputs stay stable while tvalid && !tready (AXI rule).
  - Sustains 1 beat/cycle with continuous tready.
- States:
  - IDLE:
    - If count > 0 and !empty and advance: pop the first beat, beat count = 1, then go to SEND.
    - If that beat has tlast: stay IDLE (single-beat TLP).
  - SEND:
    - Pop on advance && !empty; beat count +1 per pop.
    - Popped beat with tlast: go to IDLE, beat count = 0.
    - empty in SEND: no pop, tvalid drops after the current beat drains, set err_udr, keep waiting (no timeout).
    - Beat count reaches MAX_BEATS on a pop without tlast: force s_axis_tx_tlast = 1 on that beat, set err_long, go to FLUSH.
  - FLUSH:
    - rd_en = !empty regardless of tready; nothing is loaded to the output.
    - Popped beat with tlast: go to IDLE.
- tuser: 0, except as given under Optional Feature.
- Sticky errors clear only on reset.
- Reset mid-packet: output deasserted immediately; the FIFO is assumed to be reset alongside.

Optional Feature:
TX_DISCONTINUE_EN
- Defined: the forced-tlast beat on MAX_BEATS overflow also carries s_axis_tx_tuser[3] = 1, so the core discards the TLP.
- Not defined: tuser is constantly 0; the truncated TLP is sent as-is and only err_long reports it.

Test Plan:
- Reset, then 3-beat TLP (tkeep FF, FF, 0F) written and pkt_req pulsed, tready = 1 → 3 consecutive TX beats starting 1 cycle after the pop, tlast on beat 3, tkeep 0F, pkt_pending 1→0.
- Beats in FIFO with no pkt_req → no rd_en and tvalid stays 0. Pulse pkt_req → drain begins the next cycle.
- tready toggling 1010 during a 5-beat TLP → data stable while stalled, no beat lost or duplicated, exactly 5 pops.
- pkt_req in the same cycle as a packet start with count = 1 → count stays 1. 256 pulses with CNT_W = 8 and no drain → count 255, err_ovf = 1.
- 50-beat packet without tlast until beat 50, MAX_BEATS = 40 → 40 TX beats with tlast on beat 40, err_long = 1, 10 beats flushed, next packet sent intact. With TX_DISCONTINUE_EN, tuser = 8 on beat 40.
- FIFO empty after beat 2 of 4, refilled 5 cycles later → tvalid gap, err_udr = 1, beats 3–4 delivered with tlast on beat 4.
